// File: rtl/rob_wb_arbiter_pkg.sv
// Shared definitions between the ROB, the execution units and the writeback arbiter.
package rob_wb_arbiter_pkg;

  localparam int unsigned Q_WIDTH = 4;

  typedef struct packed {
    logic [Q_WIDTH-1:0] pos;
    logic [31:0]        val;
    logic [31:0]        pc;
  } wb_payload_t;

endpackage

// File: rtl/rob_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest set request strictly after last_i,
// found by masking a doubled copy of the request vector so the search wraps.
module rob_wb_arbiter_rr_picker #(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] lowmask_s;
  logic [2*N-1:0] masked_s;
  logic [2*N-1:0] first_s;

  always_comb begin
    dbl_s     = {req_i, req_i};
    // Two-step shift keeps last_i == N-1 from overflowing the IW-bit amount.
    lowmask_s = ((ONE << last_i) << 1) - ONE;
    masked_s  = dbl_s & ~lowmask_s;
    first_s   = masked_s & (~masked_s + ONE);
    gnt_o     = '0;
    idx_o     = '0;
    for (int i = 0; i < int'(N); i++) begin
      gnt_o[i] = first_s[i] | first_s[i+int'(N)];
      idx_o    = idx_o | ({IW{gnt_o[i]}} & IW'(i));
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the ROB execute-result write port between NUM_REQ functional units,
// each owning a one-entry holding register drained by a round-robin grant.
module rob_wb_arbiter #(
  parameter  int unsigned Q_WIDTH = rob_wb_arbiter_pkg::Q_WIDTH,
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*Q_WIDTH-1:0] req_rob_pos,
  input  logic [NUM_REQ*32-1:0]      req_value,
  input  logic [NUM_REQ*32-1:0]      req_pc,
  output logic                       has_ex_result,
  output logic [Q_WIDTH-1:0]         target_ROB_pos,
  output logic [31:0]                V_ex,
  output logic [31:0]                pc_ex,
  output logic [IDX_W-1:0]           grant_id
);

  import rob_wb_arbiter_pkg::*;

  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef struct packed {
    logic [Q_WIDTH-1:0] pos;
    logic [31:0]        val;
    logic [31:0]        pc;
  } slot_t;

  slot_t              slot_q [NUM_REQ];
  slot_t              slot_d [NUM_REQ];
  logic [NUM_REQ-1:0] hv_q, hv_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               active_s;
  logic [NUM_REQ-1:0] pick_gnt_s, gnt_s, ready_s, xfer_s;
  logic [IDX_W-1:0]   pick_idx_s, sel_s;

  rob_wb_arbiter_rr_picker #(.N(NUM_REQ)) u_picker (
    .req_i  (hv_q),
    .last_i (last_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s)
  );

  // A granted slot frees itself this cycle, so its owner may refill it at the same edge.
  always_comb begin
    active_s = rdy_in & ~flush_in;
    gnt_s    = active_s ? pick_gnt_s : '0;
    ready_s  = {NUM_REQ{active_s}} & (~hv_q | gnt_s);
    xfer_s   = req_valid & ready_s;
    sel_s    = (|gnt_s) ? pick_idx_s : '0;
  end

  assign req_ready      = ready_s;
  assign has_ex_result  = |gnt_s;
  assign target_ROB_pos = slot_q[sel_s].pos;
  assign V_ex           = slot_q[sel_s].val;
  assign pc_ex          = slot_q[sel_s].pc;
  assign grant_id       = sel_s;

  always_comb begin
    hv_d   = hv_q;
    last_d = last_q;
    slot_d = slot_q;
    if (rdy_in && flush_in) begin
      hv_d   = '0;
      last_d = LAST_INIT;
    end else if (rdy_in) begin
      hv_d   = (hv_q & ~gnt_s) | xfer_s;
      last_d = (|gnt_s) ? pick_idx_s : last_q;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        slot_d[i] = xfer_s[i] ? slot_t'{req_rob_pos[i*Q_WIDTH +: Q_WIDTH],
                                        req_value[i*32 +: 32],
                                        req_pc[i*32 +: 32]}
                              : slot_q[i];
      end
    end else begin
      hv_d   = hv_q;
      last_d = last_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hv_q   <= '0;
      last_q <= LAST_INIT;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      hv_q   <= hv_d;
      last_q <= last_d;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Randomized bench for rob_wb_arbiter with a queue-free round-robin reference model
// and directed scenarios whose literal expectations pin that model.
module tb_rob_wb_arbiter;

  localparam int N  = 3;
  localparam int QW = 4;

  logic            clk_in = 1'b0;
  logic            rst_n_in, rdy_in, flush_in;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*QW-1:0] req_rob_pos;
  logic [N*32-1:0] req_value, req_pc;
  logic            has_ex_result;
  logic [QW-1:0]   target_ROB_pos;
  logic [31:0]     V_ex, pc_ex;
  logic [1:0]      grant_id;

  int total = 0;
  int bad   = 0;

  bit          m_hv  [N];
  int          m_last;
  logic [3:0]  m_pos [N];
  logic [31:0] m_val [N];
  logic [31:0] m_pc  [N];

  rob_wb_arbiter #(.Q_WIDTH(QW), .NUM_REQ(N)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_rob_pos(req_rob_pos),
    .req_value(req_value), .req_pc(req_pc), .has_ex_result(has_ex_result),
    .target_ROB_pos(target_ROB_pos), .V_ex(V_ex), .pc_ex(pc_ex), .grant_id(grant_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (!rdy_in || flush_in) return -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (m_hv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int w);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++)
      r[i] = rdy_in && !flush_in && (!m_hv[i] || w == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
    m_last = N - 1;
  endtask

  task automatic model_check();
    int w = winner();
    int s = (w >= 0) ? w : 0;
    chk("has_ex_result", 64'(has_ex_result), 64'(w >= 0));
    chk("grant_id", 64'(grant_id), 64'(s));
    chk("req_ready", 64'(req_ready), 64'(exp_ready(w)));
    if (w >= 0) begin
      chk("target_ROB_pos", 64'(target_ROB_pos), 64'(m_pos[w]));
      chk("V_ex", 64'(V_ex), 64'(m_val[w]));
      chk("pc_ex", 64'(pc_ex), 64'(m_pc[w]));
    end
  endtask

  task automatic model_update();
    int w = winner();
    logic [N-1:0] r = exp_ready(w);
    if (!rst_n_in) begin
      model_reset();
    end else if (rdy_in && flush_in) begin
      model_reset();
    end else if (rdy_in) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && r[i]) begin
          m_hv[i]  = 1'b1;
          m_pos[i] = req_rob_pos[i*QW +: QW];
          m_val[i] = req_value[i*32 +: 32];
          m_pc[i]  = req_pc[i*32 +: 32];
        end else if (w == i) begin
          m_hv[i] = 1'b0;
        end
      end
      if (w >= 0) m_last = w;
    end
  endtask

  task automatic probe();
    @(negedge clk_in);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic set_unit(input int i, input logic [3:0] p, input logic [31:0] v, input logic [31:0] pc);
    req_rob_pos[i*QW +: QW] = p;
    req_value[i*32 +: 32]   = v;
    req_pc[i*32 +: 32]      = pc;
  endtask

  task automatic randomize_data();
    req_rob_pos = 12'($urandom);
    req_value   = {$urandom, $urandom, $urandom};
    req_pc      = {$urandom, $urandom, $urandom};
  endtask

  task automatic reset_dut();
    rst_n_in  = 1'b0;
    rdy_in    = 1'b1;
    flush_in  = 1'b0;
    req_valid = '0;
    model_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; req_valid = '0;
    randomize_data();
    reset_dut();

    // reset then idle
    probe();
    chk("rst_has", 64'(has_ex_result), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd7);
    chk("rst_gid", 64'(grant_id), 64'd0);
    advance();

    // single request from unit 1
    req_valid = 3'b010;
    set_unit(1, 4'd5, 32'hDEAD_BEEF, 32'h0000_0100);
    probe();
    advance();
    req_valid = 3'b000;
    probe();
    chk("single_has", 64'(has_ex_result), 64'd1);
    chk("single_pos", 64'(target_ROB_pos), 64'd5);
    chk("single_val", 64'(V_ex), 64'hDEAD_BEEF);
    chk("single_pc", 64'(pc_ex), 64'h100);
    chk("single_gid", 64'(grant_id), 64'd1);
    advance();
    probe();
    chk("single_after", 64'(has_ex_result), 64'd0);
    advance();

    // contention: all units continuously valid
    reset_dut();
    req_valid = 3'b111;
    randomize_data();
    probe();
    chk("cont_ready0", 64'(req_ready), 64'd7);
    advance();
    for (int k = 1; k <= 6; k++) begin
      randomize_data();
      probe();
      chk("cont_gid", 64'(grant_id), 64'((k - 1) % 3));
      chk("cont_ready", 64'(req_ready), 64'(1 << ((k - 1) % 3)));
      advance();
    end
    req_valid = '0;

    // unit 0 streams four results back to back
    reset_dut();
    for (int k = 0; k <= 4; k++) begin
      req_valid = (k < 4) ? 3'b001 : 3'b000;
      set_unit(0, 4'(k + 1), 32'(k * 17), 32'(k * 4));
      probe();
      chk("b2b_ready", 64'(req_ready[0]), 64'd1);
      if (k >= 1) begin
        chk("b2b_has", 64'(has_ex_result), 64'd1);
        chk("b2b_pos", 64'(target_ROB_pos), 64'(k));
      end
      advance();
    end

    // flush with units 0 and 2 occupied
    reset_dut();
    req_valid = 3'b101;
    randomize_data();
    probe();
    advance();
    req_valid = 3'b000;
    flush_in  = 1'b1;
    probe();
    chk("flush_has", 64'(has_ex_result), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'd0);
    advance();
    flush_in = 1'b0;
    probe();
    chk("post_flush_has", 64'(has_ex_result), 64'd0);
    advance();
    req_valid = 3'b101;
    probe();
    advance();
    req_valid = 3'b000;
    probe();
    chk("post_flush_gid", 64'(grant_id), 64'd0);
    chk("post_flush_has2", 64'(has_ex_result), 64'd1);
    advance();

    // stall with unit 2 occupied, then asynchronous reset mid-cycle
    reset_dut();
    req_valid = 3'b100;
    set_unit(2, 4'd7, 32'h1234_5678, 32'h0000_0200);
    probe();
    advance();
    req_valid = 3'b000;
    rdy_in    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      probe();
      chk("stall_has", 64'(has_ex_result), 64'd0);
      chk("stall_ready", 64'(req_ready), 64'd0);
      advance();
    end
    rdy_in = 1'b1;
    probe();
    chk("resume_has", 64'(has_ex_result), 64'd1);
    chk("resume_gid", 64'(grant_id), 64'd2);
    chk("resume_pos", 64'(target_ROB_pos), 64'd7);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_rst_has", 64'(has_ex_result), 64'd0);
    model_reset();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) reset_dut();
      rdy_in    = ($urandom_range(0, 9) != 0);
      flush_in  = ($urandom_range(0, 19) == 0);
      req_valid = 3'($urandom);
      randomize_data();
      probe();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
